ysyx_041461_exe_div: RTL and testbench

//   Multi-cycle iterative divider that serves the EXE stage as a responder: EXE issues a
//   DIV/DIVU/REM/REMU (and W variants) request via valid/ready; this block returns the
//   64-bit result via valid/ready. It replaces the single-cycle combinational divide

---
 rtl/ysyx_041461_exe_div.sv | 130 +++++++++++++
 tb/tb_ysyx_041461_exe_div.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_exe_div.sv
// Multi-cycle restoring divider for the EXE stage (DIV/DIVU/REM/REMU and W forms).
// Accepts a request in IDLE, iterates one quotient bit per cycle, and holds the result until it is taken.
module ysyx_041461_exe_div #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic            div_rem,
    input  logic [XLEN-1:0] div_dividend,
    input  logic [XLEN-1:0] div_divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [1:0]      state_dbg
);

    // Handshakes: a request transfers on a rising edge where div_valid & div_ready and
    // flush is low; a result transfers on a rising edge where out_valid & out_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] rem_q, quo_q, dsr_q;
    logic [5:0]      cnt_q;
    logic            neg_q_q, neg_r_q, sel_rem_q, word_q;

    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
    logic            a_neg, b_neg, div_zero, overflow, special, accept, last_iter;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   trial;
    logic            qbit;
    logic [XLEN-1:0] rem_n, quo_n, q_fin, r_fin, final_res;

    function automatic logic [XLEN-1:0] width_fix(input logic w, input logic [XLEN-1:0] v);
        width_fix = w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // Operand preparation: word ops are widened from bits [31:0] before anything else.
    always_comb begin
        a_ext = div_dividend;
        b_ext = div_divisor;
        if (div_word) begin
            a_ext = div_signed ? {{32{div_dividend[31]}}, div_dividend[31:0]} : {32'b0, div_dividend[31:0]};
            b_ext = div_signed ? {{32{div_divisor[31]}}, div_divisor[31:0]} : {32'b0, div_divisor[31:0]};
        end
        a_neg    = div_signed & a_ext[XLEN-1];
        b_neg    = div_signed & b_ext[XLEN-1];
        a_abs    = a_neg ? -a_ext : a_ext;
        b_abs    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        overflow = div_signed && (b_ext == '1) &&
                   (a_ext == (div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special  = div_zero | overflow;
        if (div_zero) special_res = div_rem ? a_ext : '1;
        else          special_res = div_rem ? '0 : a_ext;
        special_res = width_fix(div_word, special_res);
    end

    // One restoring step; the final step also applies sign correction and width fix.
    always_comb begin
        trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
        qbit      = ~trial[XLEN];
        rem_n     = qbit ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_n     = {quo_q[XLEN-2:0], qbit};
        q_fin     = neg_q_q ? -quo_n : quo_n;
        r_fin     = neg_r_q ? -rem_n : rem_n;
        final_res = width_fix(word_q, sel_rem_q ? r_fin : q_fin);
        last_iter = (cnt_q == (word_q ? 6'd31 : 6'd63));
    end

    always_comb begin
        state_d   = state_q;
        div_ready = (state_q == IDLE);
        out_valid = (state_q == DONE);
        state_dbg = state_q;
        accept    = (state_q == IDLE) && div_valid && !flush;
        case (state_q)
            IDLE:    if (div_valid) state_d = special ? DONE : CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            cnt_q      <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            sel_rem_q  <= 1'b0;
            word_q     <= 1'b0;
            out_result <= '0;
        end else if (accept) begin
            word_q    <= div_word;
            sel_rem_q <= div_rem;
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            dsr_q     <= b_abs;
            rem_q     <= '0;
            // Word dividends sit in the top half so 32 shifts consume exactly their bits.
            quo_q     <= div_word ? {a_abs[31:0], 32'b0} : a_abs;
            cnt_q     <= '0;
            if (special) out_result <= special_res;
        end else if (state_q == CALC && !flush) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 6'd1;
            if (last_iter) out_result <= final_res;
        end
    end

endmodule

// File: tb/tb_ysyx_041461_exe_div.sv
// Directed bench for ysyx_041461_exe_div: latency, results, special cases, hold, flush and reset.
module tb_ysyx_041461_exe_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic        div_word;
    logic        div_rem;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    ysyx_041461_exe_div #(.XLEN(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .div_valid    (div_valid),
        .div_ready    (div_ready),
        .div_signed   (div_signed),
        .div_word     (div_word),
        .div_rem      (div_rem),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Issue one op, measure latency from the accept edge, check result, then drain it.
    task automatic run_op(input string name, input logic s, input logic w, input logic r,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int   lat;
        logic seen;
        @(negedge clk);
        div_signed = s; div_word = w; div_rem = r;
        div_dividend = a; div_divisor = b; div_valid = 1'b1;
        checks++;
        if (div_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b want 1", name, div_ready);
        end
        @(posedge clk);
        #1;
        div_valid = 1'b0; div_dividend = '0; div_divisor = '0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || lat != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d (seen=%b) want %0d", name, lat, seen, exp_lat);
        end
        checks++;
        if (out_result !== exp) begin
            errors++; $display("FAIL %s result: got %h want %h", name, out_result, exp);
        end
        checks++;
        if (div_ready !== 1'b0) begin
            errors++; $display("FAIL %s ready_in_done: got %b want 0", name, div_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || div_ready !== 1'b1) begin
            errors++; $display("FAIL %s drain: got valid=%b ready=%b want 0/1", name, out_valid, div_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; div_valid = 1'b0; out_ready = 1'b0;
        div_signed = 1'b0; div_word = 1'b0; div_rem = 1'b0;
        div_dividend = '0; div_divisor = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 64'd0 || div_ready !== 1'b1 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset: got valid=%b result=%h ready=%b state=%0d want 0/0/1/0",
                     out_valid, out_result, div_ready, state_dbg);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        run_op("divu_100_7", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu_100_7", 1'b0, 1'b0, 1'b1, 64'd100, 64'd7, 64'd2, 65);
        run_op("divu_max_16", 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
        run_op("remu_max_16", 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65);
    endtask

    task automatic test_signed();
        // -7 / 2 truncates toward zero: q = -3, r = -1 so that -7 = -3*2 + -1.
        run_op("div_m7_2", 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_m7_2", 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("div_7_m2", 1'b1, 1'b0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_7_m2", 1'b1, 1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    endtask

    task automatic test_word();
        run_op("divuw_ffffffff_1", 1'b0, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divuw_100_7_hi", 1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0064, 64'h1111_1111_0000_0007, 64'd14, 33);
        run_op("remw_m7_2_hi", 1'b1, 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divw_ovf", 1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    endtask

    task automatic test_special();
        run_op("div_by_zero", 1'b1, 1'b0, 1'b0, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_by_zero", 1'b0, 1'b0, 1'b1, 64'h1234, 64'd0, 64'h1234, 1);
        run_op("div_ovf", 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("remuw_by_zero", 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1);
    endtask

    task automatic test_hold();
        logic seen;
        @(negedge clk);
        div_signed = 1'b0; div_word = 1'b0; div_rem = 1'b0;
        div_dividend = 64'd100; div_divisor = 64'd7; div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL hold_wait: got out_valid=%b want 1 within 200 cycles", out_valid);
        end
        // A request offered while DONE must be ignored (divisor 0 would finish at once).
        div_valid = 1'b1; div_divisor = 64'd0; div_dividend = 64'd55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== 64'd14 || div_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b result=%h ready=%b want 1/%h/0",
                         i, out_valid, out_result, div_ready, 64'd14);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || div_ready !== 1'b1 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL hold_release: got valid=%b ready=%b state=%0d want 0/1/0", out_valid, div_ready, state_dbg);
        end
        div_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_no_accept: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        int rises;
        @(negedge clk);
        div_signed = 1'b0; div_word = 1'b0; div_rem = 1'b0;
        div_dividend = 64'd1000; div_divisor = 64'd3; div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (state_dbg !== 2'd0 || div_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: got state=%0d ready=%b valid=%b want 0/1/0", state_dbg, div_ready, out_valid);
        end
        rises = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) rises++;
        end
        checks++;
        if (rises != 0) begin
            errors++; $display("FAIL flush_no_result: got %0d valid cycles want 0", rises);
        end
        // flush together with a request in IDLE: the request must be dropped.
        div_dividend = 64'd9; div_divisor = 64'd0; div_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || state_dbg !== 2'd0) begin
            errors++; $display("FAIL flush_idle_req: got valid=%b state=%0d want 0/0", out_valid, state_dbg);
        end
        run_op("after_flush_1000_3", 1'b0, 1'b0, 1'b0, 64'd1000, 64'd3, 64'd333, 65);
    endtask

    task automatic test_async_reset();
        int rises;
        @(negedge clk);
        div_signed = 1'b0; div_word = 1'b0; div_rem = 1'b0;
        div_dividend = 64'd500; div_divisor = 64'd9; div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || div_ready !== 1'b1 || state_dbg !== 2'd0 || out_result !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b ready=%b state=%0d result=%h want 0/1/0/0",
                     out_valid, div_ready, state_dbg, out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) rises++;
        end
        checks++;
        if (rises != 0) begin
            errors++; $display("FAIL async_reset_no_result: got %0d valid cycles want 0", rises);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_divu_1000_3", 1'b0, 1'b0, 1'b0, 64'd1000, 64'd3, 64'd333, 65);
        run_op("b2b_remu_1000_3", 1'b0, 1'b0, 1'b1, 64'd1000, 64'd3, 64'd1, 65);
        run_op("b2b_divw_m100_7", 1'b1, 1'b1, 1'b0, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_word();
        test_special();
        test_hold();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
